mem_access: RTL

- MEM-stage data-access block between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Pass-through instructions: forwards the ALU result, destination address and write enable to MEM/WB.
- Loads/stores: runs a request/acknowledge transaction on the data bus and asserts a stall request to the pipeline controller until the access completes.
- Load data is formatted (sign/zero-extension); store data is replicated onto byte lanes with byte enables.

---
 rtl/mem_access.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM-stage data access: pass-through for ALU ops, request/ack bus transaction for loads/stores.
// Latency: ALU ops combinational; loads/stores stall 2 cycles with zero-wait ack, +1 per wait state.
// Backpressure: stallreq_o held until the access completes; DONE holds results while stall[4] is Stop.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          pipeline stall vector; only stall[4] (this stage) is used
//   mem_*_i             EX/MEM register contents (wreg, rd, ALU result/address, load/store, funct3, rs2)
//   dbus_ack_i/rdata_i  data bus acknowledge and read data
//   mem_*_o             to MEM/WB (write enable, rd, write data)
//   stallreq_o          stall request to pipeline control
//   dbus_*_o            registered data bus request, write, word address, byte enables, write data
//   bus_err_o           one-cycle pulse when an access times out
//   misalign_o          (only with MISALIGN_CHECK_EN) misaligned access rejected
//
// Build option: define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses
// without touching the bus. BUS_TIMEOUT legal range is 2..65535.

module mem_access #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        mem_wreg_i,
   input  logic [4:0]  mem_rd_addr_i,
   input  logic [31:0] mem_alu_result_i,
   input  logic        mem_is_load_i,
   input  logic        mem_is_store_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [31:0] mem_store_data_i,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        mem_wreg_o,
   output logic [4:0]  mem_rd_addr_o,
   output logic [31:0] mem_rd_data_o,
   output logic        stallreq_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_be_o,
   output logic [31:0] dbus_wdata_o,
`ifdef MISALIGN_CHECK_EN
   output logic        misalign_o,
`endif
   output logic        bus_err_o
);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_ACCESS = 2'b01;
   localparam logic [1:0] S_DONE   = 2'b10;

   localparam logic STOP = 1'b1;

   localparam logic [15:0] CNT_LIMIT = 16'(BUS_TIMEOUT - 1);

   logic [1:0]  state;
   logic [15:0] cnt;
   logic [31:0] load_q;
   logic        failed;

   logic        access;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        is_unsigned;
   logic        misalign;
   logic        start;
   logic [1:0]  lane;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [31:0] rdata_fmt;

   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[3:0]};

   assign access = mem_is_load_i | mem_is_store_i;
   assign lane   = mem_alu_result_i[1:0];

   // Only the RV32I-defined encodings select byte/half; every other funct3 is a word access.
   assign is_byte     = (mem_funct3_i == 3'b000) | (mem_is_load_i & (mem_funct3_i == 3'b100));
   assign is_half     = (mem_funct3_i == 3'b001) | (mem_is_load_i & (mem_funct3_i == 3'b101));
   assign is_word     = ~is_byte & ~is_half;
   assign is_unsigned = mem_is_load_i & mem_funct3_i[2];

`ifdef MISALIGN_CHECK_EN
   assign misalign   = access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
   assign misalign_o = (state == S_IDLE) & misalign;
`else
   assign misalign   = 1'b0;
`endif

   assign start = (state == S_IDLE) & access & ~misalign;

   // Store lane steering (little-endian); loads use the same enables for the bytes they read.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = mem_store_data_i;
      if (is_byte) begin
         be_calc    = 4'b0001 << lane;
         wdata_calc = {4{mem_store_data_i[7:0]}};
      end else if (is_half) begin
         be_calc    = lane[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{mem_store_data_i[15:0]}};
      end
   end

   // Load data extraction and extension.
   always_comb begin
      rbyte = dbus_rdata_i[7:0];
      case (lane)
         2'b00:   rbyte = dbus_rdata_i[7:0];
         2'b01:   rbyte = dbus_rdata_i[15:8];
         2'b10:   rbyte = dbus_rdata_i[23:16];
         default: rbyte = dbus_rdata_i[31:24];
      endcase
      rhalf     = lane[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      rdata_fmt = dbus_rdata_i;
      if (is_byte) begin
         rdata_fmt = is_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end else if (is_half) begin
         rdata_fmt = is_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= 16'd0;
         load_q       <= 32'd0;
         failed       <= 1'b0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= 32'd0;
         dbus_be_o    <= 4'd0;
         dbus_wdata_o <= 32'd0;
         bus_err_o    <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= mem_is_store_i;
                  dbus_addr_o  <= {mem_alu_result_i[31:2], 2'b00};
                  dbus_be_o    <= be_calc;
                  dbus_wdata_o <= wdata_calc;
                  cnt          <= 16'd0;
                  failed       <= 1'b0;
                  state        <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Ack is checked first so an ack on the last allowed cycle still succeeds.
               if (dbus_ack_i) begin
                  load_q     <= rdata_fmt;
                  dbus_req_o <= 1'b0;
                  state      <= S_DONE;
               end else if (cnt == CNT_LIMIT) begin
                  load_q     <= 32'd0;
                  dbus_req_o <= 1'b0;
                  bus_err_o  <= 1'b1;
                  failed     <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DONE: begin
               // A later-stage stall keeps the finished result parked here.
               if (stall[4] != STOP) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_rd_addr_o = mem_rd_addr_i;

   always_comb begin
      mem_wreg_o    = mem_wreg_i;
      mem_rd_data_o = mem_alu_result_i;
      stallreq_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (access) begin
               mem_wreg_o = 1'b0;
               stallreq_o = ~misalign;
            end
         end
         S_ACCESS: begin
            mem_wreg_o = 1'b0;
            stallreq_o = 1'b1;
         end
         S_DONE: begin
            if (failed) begin
               mem_wreg_o    = 1'b0;
               mem_rd_data_o = 32'd0;
            end else if (mem_is_store_i) begin
               mem_wreg_o = 1'b0;
            end else if (mem_is_load_i) begin
               mem_rd_data_o = load_q;
            end
         end
         default: ;
      endcase
   end

endmodule
